// File: rtl/sap_display_driver.sv
// sap_display_driver: output-port sink for the SAP-1 CPU.
// Turns each new output-register value into three BCD digits with a serial
// shift-add-3 engine, one bit per cycle. Those digits drive a scanned
// 3-digit 7-segment display that blanks leading zeros.
module sap_display_driver #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] display_in,
  output logic       busy,
  output logic [11:0] bcd,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_CONVERT = 1'b1;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic [0:0]  state_q, state_d;
  logic [7:0]  last_q,  last_d;
  logic [19:0] work_q,  work_d;   // {bcd_work[11:0], bin[7:0]}
  logic [2:0]  iter_q,  iter_d;
  logic [11:0] bcd_q,   bcd_d;
  logic [15:0] scan_q,  scan_d;
  logic [1:0]  dig_q,   dig_d;

  logic [19:0] adj;
  logic [19:0] shifted;
  logic [3:0]  nib;
  logic        blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // One double-dabble step: correct every BCD nibble, then shift the whole register.
  always_comb begin
    adj     = {add3(work_q[19:16]), add3(work_q[15:12]), add3(work_q[11:8]), work_q[7:0]};
    shifted = {adj[18:0], 1'b0};
  end

  // Conversion FSM: capture a changed input, then run eight shift iterations.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    work_d  = work_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    case (state_q)
      S_IDLE: begin
        if (display_in != last_q) begin
          last_d  = display_in;
          work_d  = {12'h000, display_in};
          iter_d  = '0;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        work_d = shifted;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          bcd_d   = shifted[19:8];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scan timer: hold each digit for SCAN_DIV cycles, cycling ones, tens, hundreds.
  always_comb begin
    scan_d = scan_q;
    dig_d  = dig_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      dig_d  = (dig_q >= 2'd2) ? 2'd0 : dig_q + 2'd1;
    end else begin
      scan_d = scan_q + 16'd1;
    end
    if (dig_q == 2'd3) dig_d = 2'd0;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      last_q  <= '0;
      work_q  <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      scan_q  <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      work_q  <= work_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      scan_q  <= scan_d;
      dig_q   <= dig_d;
    end
  end

  // Digit select, leading-zero blanking and segment decode.
  always_comb begin
    nib   = 4'd0;
    blank = 1'b0;
    an    = 3'b000;
    case (dig_q)
      2'd0: begin
        nib = bcd_q[3:0];
        an  = 3'b001;
      end
      2'd1: begin
        nib   = bcd_q[7:4];
        blank = (bcd_q[11:4] == 8'h00);
        an    = 3'b010;
      end
      2'd2: begin
        nib   = bcd_q[11:8];
        blank = (bcd_q[11:8] == 4'h0);
        an    = 3'b100;
      end
      default: blank = 1'b1;
    endcase
    seg = blank ? 7'h00 : seg7(nib);
  end

  assign busy = (state_q == S_CONVERT);
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_sap_display_driver.sv
// Bench for sap_display_driver: a transaction-level model (pending value plus
// remaining-cycle countdown, decimal by division, scan by cycle count) checked
// every cycle, plus literal expectations from the directed scenarios.
module tb_sap_display_driver;

  localparam int unsigned SD = 4;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [7:0]  display_in = 8'd0;
  logic        busy;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  an;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  sap_display_driver #(.SCAN_DIV(SD)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .display_in (display_in),
    .busy       (busy),
    .bcd        (bcd),
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] digit_seg(input int d);
    logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return t[d];
  endfunction

  // Reference model: value-level behaviour, not the datapath.
  logic [7:0] m_last;
  logic [7:0] m_pend;
  int         m_rem;
  int         m_val;
  int         m_cyc;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_last <= 8'd0;
      m_pend <= 8'd0;
      m_rem  <= 0;
      m_val  <= 0;
      m_cyc  <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_rem == 0) begin
        if (display_in != m_last) begin
          m_last <= display_in;
          m_pend <= display_in;
          m_rem  <= 8;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_val <= int'(m_pend);
      end
    end
  end

  // Compare process: every cycle while out of reset.
  int run_len = 0;
  always @(negedge clk) begin
    int dig;
    int h, t, o;
    logic [6:0] es;
    if (cmp_en && clrn) begin
      dig = (m_cyc / SD) % 3;
      h = m_val / 100;
      t = (m_val / 10) % 10;
      o = m_val % 10;
      if (dig == 0)      es = digit_seg(o);
      else if (dig == 1) es = (h == 0 && t == 0) ? 7'h00 : digit_seg(t);
      else               es = (h == 0) ? 7'h00 : digit_seg(h);
      chk("busy", int'(busy), (m_rem != 0) ? 1 : 0);
      chk("bcd", int'(bcd), int'(to_bcd(m_val)));
      chk("an", int'(an), 1 << dig);
      chk("seg", int'(seg), int'(es));
      if (busy) run_len++;
      else begin
        if (run_len > 0) chk("busy_len", run_len, 8);
        run_len = 0;
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk(name, int'(busy), 0);
  endtask

  task automatic wait_an(input logic [2:0] target, input logic [6:0] exp_seg, input string name);
    int n = 0;
    @(negedge clk);
    while (an != target && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_an"}, int'(an), int'(target));
    chk(name, int'(seg), int'(exp_seg));
  endtask

  task automatic convert(input logic [7:0] v);
    display_in = v;
    tick();
    repeat (10) tick();
  endtask

  initial begin
    int n;
    // Reset state while held low.
    #13;
    chk("rst_bcd", int'(bcd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_an", int'(an), 1);
    chk("rst_seg", int'(seg), 'h3F);
    tick();
    clrn = 1'b1;
    cmp_en = 1'b1;
    // Input 0 after reset must not start a conversion.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_busy", int'(busy), 0);
      chk("idle_bcd", int'(bcd), 0);
    end

    // Full scale.
    display_in = 8'd255;
    tick();
    chk("fs_busy", int'(busy), 1);
    repeat (7) tick();
    chk("fs_busy7", int'(busy), 1);
    tick();
    chk("fs_busy8", int'(busy), 0);
    chk("fs_bcd", int'(bcd), 'h255);
    wait_an(3'b001, 7'h6D, "fs_ones");
    wait_an(3'b010, 7'h6D, "fs_tens");
    wait_an(3'b100, 7'h5B, "fs_hund");

    // Blanking.
    tick();
    convert(8'd7);
    chk("b7_bcd", int'(bcd), 'h007);
    wait_an(3'b001, 7'h07, "b7_ones");
    wait_an(3'b010, 7'h00, "b7_tens");
    wait_an(3'b100, 7'h00, "b7_hund");
    tick();
    convert(8'd40);
    chk("b40_bcd", int'(bcd), 'h040);
    wait_an(3'b001, 7'h3F, "b40_ones");
    wait_an(3'b010, 7'h66, "b40_tens");
    wait_an(3'b100, 7'h00, "b40_hund");

    // Overwrite during conversion.
    tick();
    display_in = 8'd100;
    tick();
    repeat (3) tick();
    display_in = 8'd42;
    repeat (5) tick();
    chk("ow_bcd1", int'(bcd), 'h100);
    chk("ow_gap", int'(busy), 0);
    tick();
    chk("ow_busy2", int'(busy), 1);
    repeat (8) tick();
    chk("ow_bcd2", int'(bcd), 'h042);

    // Asynchronous reset mid-conversion.
    tick();
    display_in = 8'd200;
    tick();
    repeat (4) tick();
    clrn = 1'b0;
    #1;
    chk("mr_bcd", int'(bcd), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_an", int'(an), 1);
    chk("mr_seg", int'(seg), 'h3F);
    tick();
    clrn = 1'b1;
    n = 0;
    while (bcd != 12'h200 && n < 15) begin
      tick();
      n++;
    end
    chk("mr_reconv", int'(bcd), 'h200);
    chk("mr_latency", n, 9);

    // Randomized input changes, model checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) display_in = 8'($urandom_range(0, 255));
      tick();
    end
    wait_idle("rnd_idle");

    // Sweep every value.
    for (int v = 0; v < 256; v++) begin
      display_in = 8'(v);
      tick();
      wait_idle("sw_idle");
      chk("sw_bcd", int'(bcd), int'(to_bcd(v)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
